spike_collector: RTL and testbench

Per-bank spike harvester between a `neuron_bank` and the NoC injection port. On each `scan_start` it reads the bank's spike status register (0xC2) over the bank's CPU-style register bus. For every neuron that spiked, it pushes a 32-bit spike event into an internal FIFO and writes the neuron's spike-resolved control register. The FIFO drains to the NoC through a valid/ready handshake; a 16-bit timestep counter stamps every event.

---
 rtl/spike_collector_if.sv | 28 ++
 rtl/spike_collector.sv | 203 ++++++++++++++++++++
 tb/tb_spike_collector.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_collector_if.sv
// Bank register bus plus NoC spike stream between spike_collector (master) and its environment (slave).
interface spike_collector_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] bus_address;
    logic                  bus_read_enable;
    logic                  bus_write_enable;
    logic [31:0]           bus_write_data;
    logic [31:0]           bus_read_data;
    logic                  bus_ready;
    logic                  spike_valid;
    logic [31:0]           spike_data;
    logic                  spike_ready;

    modport master (
        output bus_address, bus_read_enable, bus_write_enable, bus_write_data,
        input  bus_read_data, bus_ready,
        output spike_valid, spike_data,
        input  spike_ready
    );

    modport slave (
        input  bus_address, bus_read_enable, bus_write_enable, bus_write_data,
        output bus_read_data, bus_ready,
        input  spike_valid, spike_data,
        output spike_ready
    );
endinterface

// File: rtl/spike_collector.sv
// Spike harvester: reads a bank's spike status, writes each neuron's resolve register and queues a stamped event.
// Latency: event visible one cycle after its accepted write; stalls on bus_ready=0 or a full event FIFO.
module spike_collector_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic                     o_vld,
    output logic [WIDTH-1:0]         o_dat,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end

    assign o_vld   = (r_count != '0);
    assign o_dat   = o_vld ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;
endmodule

module spike_collector #(
    parameter int NUM_NEURONS = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  bank_id,
    input  logic                        scan_start,
    output logic                        busy,
    output logic                        scan_done,
    output logic [15:0]                 timestep,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    spike_collector_if.master           bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(8'hC2);

    typedef enum logic [2:0] {IDLE, RD_STATUS, WAIT_STATUS, SCAN, DONE} state_t;

    // Neuron n's spike-resolved control register lives at n*8+7.
    function automatic logic [ADDR_WIDTH-1:0] ctrl_addr(input logic [4:0] n);
        return ADDR_WIDTH'(32'(n) * 32'd8 + 32'd7);
    endfunction

    function automatic logic [4:0] lowest_bit(input logic [NUM_NEURONS-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    state_t                 r_state;
    logic [NUM_NEURONS-1:0] r_pending;
    logic [4:0]             r_sel;
    logic [15:0]            r_timestep;
    logic                   r_busy;
    logic                   r_scan_done;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_rd_en;
    logic                   r_wr_en;
    logic [31:0]            r_wr_dat;

    logic [NUM_NEURONS-1:0] w_status;
    logic [NUM_NEURONS-1:0] w_pend_next;
    logic [4:0]             w_status_sel;
    logic [4:0]             w_next_sel;
    logic                   w_full;
    logic                   w_accept;
    logic                   w_pop;
    logic [31:0]            w_push_dat;
    logic                   w_unused_rd;

    assign w_status     = bus.bus_read_data[NUM_NEURONS-1:0];
    assign w_unused_rd  = ^bus.bus_read_data;
    assign w_status_sel = lowest_bit(w_status);
    assign w_pend_next  = r_pending & ~(NUM_NEURONS'(1) << r_sel);
    assign w_next_sel   = lowest_bit(w_pend_next);
    // Full is judged on the registered count so a same-cycle pop never frees a slot early.
    assign w_full       = (fifo_count == CW'(FIFO_DEPTH));
    assign w_accept     = (r_state == SCAN) && (r_pending != '0) && bus.bus_ready && !w_full;
    assign w_pop        = bus.spike_valid && bus.spike_ready;
    assign w_push_dat   = {bank_id, 3'b000, r_sel, r_timestep};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_sel       <= '0;
            r_timestep  <= '0;
            r_busy      <= 1'b0;
            r_scan_done <= 1'b0;
            r_addr      <= '0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_dat    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_scan_done <= 1'b0;
                    if (scan_start) begin
                        r_state <= RD_STATUS;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_addr  <= STATUS_ADDR;
                    end
                end
                RD_STATUS: begin
                    if (bus.bus_ready) begin
                        r_state <= WAIT_STATUS;
                        r_rd_en <= 1'b0;
                        r_addr  <= '0;
                    end
                end
                WAIT_STATUS: begin
                    // Write strobes for the first neuron are set up here so they are registered in SCAN.
                    r_pending <= w_status;
                    r_sel     <= w_status_sel;
                    r_state   <= SCAN;
                    if (w_status != '0) begin
                        r_wr_en  <= 1'b1;
                        r_wr_dat <= 32'd1;
                        r_addr   <= ctrl_addr(w_status_sel);
                    end
                end
                SCAN: begin
                    if (r_pending == '0) begin
                        r_state     <= DONE;
                        r_scan_done <= 1'b1;
                    end else if (w_accept) begin
                        r_pending <= w_pend_next;
                        r_sel     <= w_next_sel;
                        if (w_pend_next != '0) begin
                            r_addr <= ctrl_addr(w_next_sel);
                        end else begin
                            r_wr_en  <= 1'b0;
                            r_wr_dat <= '0;
                            r_addr   <= '0;
                        end
                    end
                end
                DONE: begin
                    r_scan_done <= 1'b0;
                    r_busy      <= 1'b0;
                    r_timestep  <= r_timestep + 16'd1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    spike_collector_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_accept),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_vld      (bus.spike_valid),
        .o_dat      (bus.spike_data),
        .o_count    (fifo_count)
    );

    assign busy                 = r_busy;
    assign scan_done            = r_scan_done;
    assign timestep             = r_timestep;
    assign bus.bus_address      = r_addr;
    assign bus.bus_read_enable  = r_rd_en;
    assign bus.bus_write_enable = r_wr_en;
    assign bus.bus_write_data   = r_wr_dat;
endmodule

// File: tb/tb_spike_collector.sv
// Bench for spike_collector: vector table, directed stall/reset/wrap sequences, random scans vs an event-queue model.
module tb_spike_collector;
    localparam int NN    = 4;
    localparam int AW    = 8;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  bank_id = 8'h00;
    logic        scan_start = 1'b0;
    logic        busy, scan_done;
    logic [15:0] timestep;
    logic [3:0]  fifo_count;

    spike_collector_if #(.ADDR_WIDTH(AW)) bif();

    spike_collector #(.NUM_NEURONS(NN), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bank_id    (bank_id),
        .scan_start (scan_start),
        .busy       (busy),
        .scan_done  (scan_done),
        .timestep   (timestep),
        .fifo_count (fifo_count),
        .bus        (bif)
    );

    always #5 clk = ~clk;

    int          vec = 0;
    int          err = 0;
    logic [31:0] status_reg = '0;
    logic [31:0] exp_q[$];
    int          wr_log[$];
    int          last_wr = -1;
    logic [15:0] ts_m = '0;
    bit          rnd = 1'b0;
    int          cyc = 0;
    int          done_c;

    typedef struct {
        logic [31:0] status;
        logic [7:0]  bid;
        int          done_cyc;
        int          nwr;
        logic [31:0] wr_addrs;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bank model: status register read data is registered, returned the cycle after acceptance.
    always @(posedge clk) begin
        if (bif.bus_read_enable && bif.bus_ready && bif.bus_address == 8'hC2)
            bif.bus_read_data <= status_reg;
    end

    // Scoreboard and write log, sampled between the driving negedge and the next posedge.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (bif.spike_valid && bif.spike_ready) begin
                if (exp_q.size() == 0) chk("unexpected_event", bif.spike_data, 32'hDEAD_BEEF);
                else chk("spike_data", bif.spike_data, exp_q.pop_front());
            end
            if (bif.bus_read_enable && bif.bus_write_enable) chk("strobe_excl", 32'd1, 32'd0);
            if (bif.bus_write_enable && int'(bif.bus_address) != last_wr) begin
                last_wr = int'(bif.bus_address);
                wr_log.push_back(last_wr);
                chk("wr_data", bif.bus_write_data, 32'd1);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        cyc++;
        if (rnd) begin
            bif.bus_ready   = ($urandom_range(0, 3) != 0);
            bif.spike_ready = ($urandom_range(0, 4) > 1);
        end
    endtask

    task automatic start_scan(input logic [31:0] st);
        status_reg = st;
        last_wr = -1;
        wr_log.delete();
        for (int i = 0; i < NN; i++)
            if (st[i]) exp_q.push_back({bank_id, 8'(i), ts_m});
        @(negedge clk);
        scan_start = 1'b1;
        @(posedge clk);
        #1 scan_start = 1'b0;
        cyc = 0;
    endtask

    task automatic finish_scan(input logic [63:0] pat, input bit use_pat, output int dc);
        logic        p_rdy, p_re, p_we;
        logic [7:0]  p_addr;
        p_rdy = 1'b1; p_re = 1'b0; p_we = 1'b0; p_addr = '0;
        dc = -1;
        while (cyc < 300) begin
            step();
            if (use_pat && cyc < 64) bif.bus_ready = pat[cyc];
            if (cyc == 1) begin
                chk("status_rd_en", {31'd0, bif.bus_read_enable}, 32'd1);
                chk("status_addr", {24'd0, bif.bus_address}, 32'hC2);
            end
            if (!p_rdy && (p_re || p_we)) begin
                chk("held_strobes", {bif.bus_read_enable, bif.bus_write_enable, bif.bus_address},
                    {p_re, p_we, p_addr});
            end
            if (scan_done) begin
                dc = cyc;
                break;
            end
            chk("busy_in_scan", {31'd0, busy}, 32'd1);
            p_rdy = bif.bus_ready; p_re = bif.bus_read_enable;
            p_we = bif.bus_write_enable; p_addr = bif.bus_address;
        end
        if (dc < 0) begin
            chk("scan_timeout", 32'd0, 32'd1);
        end else begin
            ts_m = ts_m + 16'd1;
            step();
            chk("busy_idle", {31'd0, busy}, 32'd0);
            chk("timestep", {16'd0, timestep}, {16'd0, ts_m});
        end
    endtask

    task automatic run_scan(input logic [31:0] st, input logic [63:0] pat, input bit use_pat, output int dc);
        start_scan(st);
        finish_scan(pat, use_pat, dc);
    endtask

    task automatic check_writes(input logic [31:0] st);
        int exp_w[$];
        for (int i = 0; i < NN; i++) if (st[i]) exp_w.push_back(i * 8 + 7);
        chk("wr_count", wr_log.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++)
            chk("wr_addr", wr_log[i], exp_w[i]);
    endtask

    task automatic drain();
        int n;
        rnd = 1'b0;
        bif.spike_ready = 1'b1;
        n = 0;
        while (bif.spike_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_empty", {31'd0, bif.spike_valid}, 32'd0);
        chk("model_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        tbl[0] = '{32'h0000_0000, 8'h00, 4, 0, 32'h0000_0000};
        tbl[1] = '{32'h0000_0005, 8'h03, 6, 2, 32'h0000_1707};
        tbl[2] = '{32'h0000_000F, 8'h11, 8, 4, 32'h1F17_0F07};
        tbl[3] = '{32'h0000_0008, 8'hA5, 5, 1, 32'h0000_001F};
        tbl[4] = '{32'hFFFF_FFF0, 8'h42, 4, 0, 32'h0000_0000};
        tbl[5] = '{32'h0000_000A, 8'hFF, 6, 2, 32'h0000_1F0F};
        tbl[6] = '{32'h8000_0001, 8'h7E, 5, 1, 32'h0000_0007};

        bif.bus_ready = 1'b1;
        bif.spike_ready = 1'b1;
        bif.bus_read_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fifo_count", {28'd0, fifo_count}, 32'd0);
        chk("rst_timestep", {16'd0, timestep}, 32'd0);
        chk("rst_strobes", {30'd0, bif.bus_read_enable, bif.bus_write_enable}, 32'd0);
        chk("rst_spike_valid", {31'd0, bif.spike_valid}, 32'd0);
        rst_n = 1'b1;

        // Nominal scans, no stalls, NoC always ready
        for (int v = 0; v < 7; v++) begin
            bank_id = tbl[v].bid;
            run_scan(tbl[v].status, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, done_c);
            chk("done_cycle", done_c, tbl[v].done_cyc);
            chk("wr_count_tbl", wr_log.size(), tbl[v].nwr);
            for (int i = 0; i < tbl[v].nwr && i < wr_log.size(); i++)
                chk("wr_addr_tbl", wr_log[i], {24'd0, tbl[v].wr_addrs[8*i +: 8]});
        end
        drain();

        // Bus stalls: 3 cycles in RD_STATUS, 2 on the first SCAN write
        bank_id = 8'h03;
        run_scan(32'h5, ~64'h0000_0000_0000_00CE, 1'b1, done_c);
        chk("stall_done_cycle", done_c, 32'd11);
        check_writes(32'h5);
        drain();

        // FIFO full: two scans fill 8 entries, third scan stalls on neuron 0
        bif.spike_ready = 1'b0;
        run_scan(32'hF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, done_c);
        run_scan(32'hF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, done_c);
        chk("full_count", {28'd0, fifo_count}, 32'd8);
        start_scan(32'h3);
        repeat (8) step();
        chk("full_we_held", {31'd0, bif.bus_write_enable}, 32'd1);
        chk("full_addr_held", {24'd0, bif.bus_address}, 32'h07);
        bif.spike_ready = 1'b1;
        step();
        bif.spike_ready = 1'b0;
        chk("pop_no_push_count", {28'd0, fifo_count}, 32'd7);
        chk("pop_addr_still", {24'd0, bif.bus_address}, 32'h07);
        step();
        chk("refill_count", {28'd0, fifo_count}, 32'd8);
        chk("next_addr", {24'd0, bif.bus_address}, 32'h0F);
        bif.spike_ready = 1'b1;
        finish_scan(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, done_c);
        check_writes(32'h3);
        drain();

        // Randomized scans against the event-queue model
        rnd = 1'b1;
        for (int s = 0; s < 40; s++) begin
            bank_id = 8'($urandom);
            run_scan($urandom, 64'd0, 1'b0, done_c);
            check_writes(status_reg);
        end
        drain();

        // Timestep wrap
        bif.bus_ready = 1'b1;
        @(negedge clk);
        force dut.r_timestep = 16'hFFFF;
        @(negedge clk);
        release dut.r_timestep;
        ts_m = 16'hFFFF;
        run_scan(32'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, done_c);
        chk("wrap_ts", {16'd0, timestep}, 32'd0);
        run_scan(32'h2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, done_c);
        drain();

        // Reset in the middle of SCAN with 3 events queued
        bif.spike_ready = 1'b0;
        start_scan(32'hF);
        repeat (6) step();
        chk("pre_rst_count", {28'd0, fifo_count}, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {30'd0, busy, scan_done}, 32'd0);
        chk("mid_rst_strobes", {30'd0, bif.bus_read_enable, bif.bus_write_enable}, 32'd0);
        chk("mid_rst_addr", {24'd0, bif.bus_address}, 32'd0);
        chk("mid_rst_wdata", bif.bus_write_data, 32'd0);
        chk("mid_rst_spike", {31'd0, bif.spike_valid}, 32'd0);
        chk("mid_rst_spike_data", bif.spike_data, 32'd0);
        chk("mid_rst_count", {28'd0, fifo_count}, 32'd0);
        chk("mid_rst_ts", {16'd0, timestep}, 32'd0);
        exp_q.delete();
        ts_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bif.spike_ready = 1'b1;
        bank_id = 8'h5A;
        run_scan(32'h2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, done_c);
        chk("post_rst_done", done_c, 32'd5);
        check_writes(32'h2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
